// File: rtl/exec_result_writeback_pkg.sv
// Shared constants for the execution write-back stage: default widths, FIFO depth
// and the zero-register index.
package exec_result_writeback_pkg;

   localparam int unsigned DATA_WIDTH_DEF = 32;
   localparam int unsigned REG_ADDR_W_DEF = 5;
   localparam int unsigned WB_DEPTH_DEF   = 4;
   localparam int unsigned REG_X0         = 0;

endpackage

// File: rtl/exec_result_writeback_wb_fifo.sv
// wb_fifo: in-order circular result buffer with write/read pointers and a count.
// Entry contents are exported so the parent can search pending results.
module exec_result_writeback_wb_fifo
   import exec_result_writeback_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int unsigned ADDR_W     = REG_ADDR_W_DEF,
   parameter int unsigned DEPTH      = WB_DEPTH_DEF
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic [ADDR_W-1:0]          push_rd,
   input  logic [DATA_WIDTH-1:0]      push_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count,
   output logic [$clog2(DEPTH)-1:0]   rd_ptr,
   output logic [ADDR_W-1:0]          head_rd,
   output logic [DATA_WIDTH-1:0]      head_data,
   output logic [ADDR_W-1:0]          ent_rd   [DEPTH],
   output logic [DATA_WIDTH-1:0]      ent_data [DEPTH]
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [ADDR_W-1:0]     mem_rd_q   [DEPTH];
   logic [ADDR_W-1:0]     mem_rd_d   [DEPTH];
   logic [DATA_WIDTH-1:0] mem_data_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_data_d [DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;

   // Next-state: pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      mem_rd_d   = mem_rd_q;
      mem_data_d = mem_data_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = CNT_W'(count_q + CNT_W'(push) - CNT_W'(pop));
      if (push) begin
         mem_rd_d[wr_ptr_q]   = push_rd;
         mem_data_d[wr_ptr_q] = push_data;
         wr_ptr_d             = PTR_W'(wr_ptr_q + PTR_W'(1));
      end
      if (pop) begin
         rd_ptr_d = PTR_W'(rd_ptr_q + PTR_W'(1));
      end
   end

   // Entries are cleared on reset so the head outputs read as zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_rd_q[i]   <= '0;
            mem_data_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_rd_q   <= mem_rd_d;
         mem_data_q <= mem_data_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

   assign full      = (count_q == CNT_W'(DEPTH));
   assign empty     = (count_q == '0);
   assign count     = count_q;
   assign rd_ptr    = rd_ptr_q;
   assign head_rd   = mem_rd_q[rd_ptr_q];
   assign head_data = mem_data_q[rd_ptr_q];
   assign ent_rd    = mem_rd_q;
   assign ent_data  = mem_data_q;

endmodule

// File: rtl/exec_result_writeback.sv
// Write-back stage: buffers execution results, drains them to the register file,
// drops x0 results; forwarding search is built only when WB_FORWARD_EN is defined.
module exec_result_writeback
   import exec_result_writeback_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF,
   parameter int unsigned DEPTH      = WB_DEPTH_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     res_valid,
   output logic                     res_ready,
   input  logic [DATA_WIDTH-1:0]    res_data,
   input  logic [REG_ADDR_W-1:0]    res_rd,
   output logic                     rf_wr_en,
   output logic [REG_ADDR_W-1:0]    rf_wr_addr,
   output logic [DATA_WIDTH-1:0]    rf_wr_data,
   input  logic                     rf_wr_gnt,
   input  logic [REG_ADDR_W-1:0]    fwd_rs_addr,
   output logic                     fwd_hit,
   output logic [DATA_WIDTH-1:0]    fwd_data,
   output logic [$clog2(DEPTH):0]   occupancy
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic                   full;
   logic                   empty;
   logic                   accept;
   logic                   push;
   logic                   pop;
   logic [CNT_W-1:0]       count;
   logic [PTR_W-1:0]       rd_ptr;
   logic [REG_ADDR_W-1:0]  ent_rd   [DEPTH];
   logic [DATA_WIDTH-1:0]  ent_data [DEPTH];

   // x0 results complete the handshake but never occupy an entry.
   assign res_ready = ~full;
   assign accept    = res_valid & res_ready;
   assign push      = accept & (res_rd != REG_ADDR_W'(REG_X0));
   assign rf_wr_en  = ~empty;
   assign pop       = rf_wr_en & rf_wr_gnt;
   assign occupancy = count;

   exec_result_writeback_wb_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_W     (REG_ADDR_W),
      .DEPTH      (DEPTH)
   ) u_wb_fifo (
      .clk       (clk),
      .rst_n     (reset),
      .push      (push),
      .pop       (pop),
      .push_rd   (res_rd),
      .push_data (res_data),
      .full      (full),
      .empty     (empty),
      .count     (count),
      .rd_ptr    (rd_ptr),
      .head_rd   (rf_wr_addr),
      .head_data (rf_wr_data),
      .ent_rd    (ent_rd),
      .ent_data  (ent_data)
   );

`ifdef WB_FORWARD_EN
   // Walk oldest to youngest so the last match wins.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         if ((CNT_W'(k) < count) &&
             (fwd_rs_addr != REG_ADDR_W'(REG_X0)) &&
             (ent_rd[PTR_W'(rd_ptr + PTR_W'(k))] == fwd_rs_addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = ent_data[PTR_W'(rd_ptr + PTR_W'(k))];
         end
      end
   end
`else
   logic unused_fwd;

   assign fwd_hit  = 1'b0;
   assign fwd_data = '0;

   always_comb begin
      unused_fwd = (^fwd_rs_addr) ^ (^rd_ptr);
      for (int unsigned k = 0; k < DEPTH; k++) begin
         unused_fwd = unused_fwd ^ (^ent_rd[k]) ^ (^ent_data[k]);
      end
   end
`endif

endmodule

// File: tb/tb_exec_result_writeback.sv
// Bench for exec_result_writeback: directed scenarios plus random traffic, all
// checked against a queue-based model of the pending results.
module tb_exec_result_writeback;

   localparam int unsigned DW    = 32;
   localparam int unsigned AW    = 5;
   localparam int unsigned DEPTH = 4;

   typedef struct {
      logic [AW-1:0] rd;
      logic [DW-1:0] data;
   } ent_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          res_valid;
   logic          res_ready;
   logic [DW-1:0] res_data;
   logic [AW-1:0] res_rd;
   logic          rf_wr_en;
   logic [AW-1:0] rf_wr_addr;
   logic [DW-1:0] rf_wr_data;
   logic          rf_wr_gnt;
   logic [AW-1:0] fwd_rs_addr;
   logic          fwd_hit;
   logic [DW-1:0] fwd_data;
   logic [2:0]    occupancy;

   ent_t model_q[$];
   int   n_total = 0;
   int   n_bad   = 0;

   exec_result_writeback #(.DATA_WIDTH(DW), .REG_ADDR_W(AW), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .reset       (reset),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_data    (res_data),
      .res_rd      (res_rd),
      .rf_wr_en    (rf_wr_en),
      .rf_wr_addr  (rf_wr_addr),
      .rf_wr_data  (rf_wr_data),
      .rf_wr_gnt   (rf_wr_gnt),
      .fwd_rs_addr (fwd_rs_addr),
      .fwd_hit     (fwd_hit),
      .fwd_data    (fwd_data),
      .occupancy   (occupancy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Compare every output with what the pending-result queue implies.
   task automatic check_outputs(input string ctx);
      logic          exp_hit;
      logic [DW-1:0] exp_data;
      exp_hit  = 1'b0;
      exp_data = '0;
      check({ctx, ".ready"}, 64'(res_ready), 64'(model_q.size() < DEPTH));
      check({ctx, ".occ"},   64'(occupancy), 64'(model_q.size()));
      check({ctx, ".wr_en"}, 64'(rf_wr_en),  64'(model_q.size() != 0));
      if (model_q.size() != 0) begin
         check({ctx, ".wr_addr"}, 64'(rf_wr_addr), 64'(model_q[0].rd));
         check({ctx, ".wr_data"}, 64'(rf_wr_data), 64'(model_q[0].data));
      end else begin
         check({ctx, ".addr_x"}, 64'($isunknown(rf_wr_addr)), 64'(0));
         check({ctx, ".data_x"}, 64'($isunknown(rf_wr_data)), 64'(0));
      end
`ifdef WB_FORWARD_EN
      if (fwd_rs_addr != 0) begin
         foreach (model_q[i]) begin
            if (model_q[i].rd == fwd_rs_addr) begin
               exp_hit  = 1'b1;
               exp_data = model_q[i].data;
            end
         end
      end
      check({ctx, ".fwd_hit"}, 64'(fwd_hit), 64'(exp_hit));
      if (exp_hit) check({ctx, ".fwd_data"}, 64'(fwd_data), 64'(exp_data));
`else
      check({ctx, ".fwd_hit"},  64'(fwd_hit),  64'(exp_hit));
      check({ctx, ".fwd_data"}, 64'(fwd_data), 64'(exp_data));
`endif
   endtask

   // One cycle: drive at the falling edge, check, clock, then advance the model.
   task automatic step(input string ctx, input logic v, input logic [AW-1:0] rd,
                       input logic [DW-1:0] d, input logic g, input logic [AW-1:0] rs);
      bit rdy;
      bit do_pop;
      res_valid   = v;
      res_rd      = rd;
      res_data    = d;
      rf_wr_gnt   = g;
      fwd_rs_addr = rs;
      #1;
      check_outputs(ctx);
      rdy    = (model_q.size() < DEPTH);
      do_pop = (model_q.size() != 0) && g;
      @(posedge clk);
      if (do_pop) void'(model_q.pop_front());
      if (v && rdy && (rd != 0)) model_q.push_back('{rd: rd, data: d});
      @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string ctx);
      check({ctx, ".wr_en"},    64'(rf_wr_en),   64'(0));
      check({ctx, ".wr_addr"},  64'(rf_wr_addr), 64'(0));
      check({ctx, ".wr_data"},  64'(rf_wr_data), 64'(0));
      check({ctx, ".fwd_hit"},  64'(fwd_hit),    64'(0));
      check({ctx, ".fwd_data"}, 64'(fwd_data),   64'(0));
      check({ctx, ".occ"},      64'(occupancy),  64'(0));
   endtask

   initial begin
      reset       = 1'b0;
      res_valid   = 1'b0;
      res_rd      = '0;
      res_data    = '0;
      rf_wr_gnt   = 1'b0;
      fwd_rs_addr = 5'd3;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("por");
      reset = 1'b1;
      @(negedge clk);
      check("por.ready", 64'(res_ready), 64'(1));

      // Single result with grant held high.
      step("single.acc", 1'b1, 5'd5, 32'h0000_00FF, 1'b1, 5'd5);
      check("single.lat_en",   64'(rf_wr_en),   64'(1));
      check("single.lat_addr", 64'(rf_wr_addr), 64'(5));
      check("single.lat_data", 64'(rf_wr_data), 64'(32'hFF));
      step("single.drain", 1'b0, 5'd0, 32'h0, 1'b1, 5'd5);
      step("single.empty", 1'b0, 5'd0, 32'h0, 1'b1, 5'd5);

      // Fill with grant low, then offer a fifth result.
      for (int i = 1; i <= 4; i++)
         step("fill.push", 1'b1, AW'(i), DW'(32'h100 + i), 1'b0, 5'd2);
      check("fill.ready", 64'(res_ready), 64'(0));
      check("fill.occ",   64'(occupancy), 64'(4));
      step("fill.fifth", 1'b1, 5'd9, 32'h999, 1'b0, 5'd9);
      for (int i = 0; i < 5; i++)
         step("fill.drain", 1'b0, 5'd0, 32'h0, 1'b1, 5'd4);

      // x0 result: accepted, discarded.
      step("x0.offer", 1'b1, 5'd0, 32'hDEAD_BEEF, 1'b1, 5'd0);
      step("x0.after", 1'b0, 5'd0, 32'h0, 1'b1, 5'd0);

      // Forwarding: two pending writes to the same register.
      step("fwd.p1", 1'b1, 5'd7, 32'h11, 1'b0, 5'd7);
      step("fwd.p2", 1'b1, 5'd7, 32'h22, 1'b0, 5'd7);
      step("fwd.rs7", 1'b0, 5'd0, 32'h0, 1'b0, 5'd7);
      step("fwd.rs0", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);

      // Simultaneous accept and pop at occupancy 2.
      for (int i = 0; i < 3; i++)
         step("sim.acc_pop", 1'b1, AW'(10 + i), DW'(32'hA0 + i), 1'b1, 5'd7);
      check("sim.occ", 64'(occupancy), 64'(2));
      for (int i = 0; i < 3; i++)
         step("sim.drain", 1'b0, 5'd0, 32'h0, 1'b1, 5'd11);

      // Reset mid-drain at occupancy 3.
      for (int i = 0; i < 3; i++)
         step("rst.fill", 1'b1, AW'(20 + i), DW'(32'hC0 + i), 1'b0, 5'd21);
      check("rst.occ3", 64'(occupancy), 64'(3));
      rf_wr_gnt = 1'b1;
      res_valid = 1'b0;
      #2 reset = 1'b0;
      #1;
      check_reset_outputs("rst.async");
      model_q.delete();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 3; i++)
         step("rst.after", 1'b0, 5'd0, 32'h0, 1'b1, 5'd21);

      // Random traffic with a narrow register range to provoke forwarding hits.
      for (int i = 0; i < 600; i++)
         step("rand",
              ($urandom_range(0, 3) != 0),
              AW'($urandom_range(0, 7)),
              DW'($urandom),
              ($urandom_range(0, 2) != 0),
              AW'($urandom_range(0, 7)));

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/exec_result_writeback.md
# exec_result_writeback

Write-back stage behind the execution units (logical unit first, arithmetic/shift units later). It accepts single-cycle results over a valid/ready handshake and buffers them in a small in-order FIFO. It drains them to the register-file write port when that port is granted, and optionally forwards pending (not yet written) values to operand read.

## Interface
Parameters:
- DATA_WIDTH, default `DATA_WIDTH` (32): result width.
- REG_ADDR_W, default 5: destination register index width.
- DEPTH, default 4: FIFO entries, power of two, minimum 2.

Ports:
- clk  input  1  rising-edge clock for all state.
- reset  input  1  asynchronous, active-low reset.
- res_valid  input  1  result offered by an execution unit.
- res_ready  output  1  buffer can accept a result this cycle.
- res_data  input  DATA_WIDTH  result value, for example the logical unit's output.
- res_rd  input  REG_ADDR_W  destination register.
- rf_wr_en  output  1  head entry presented to the register file.
- rf_wr_addr  output  REG_ADDR_W  head destination.
- rf_wr_data  output  DATA_WIDTH  head value.
- rf_wr_gnt  input  1  register-file write port accepts the presented entry this cycle.
- fwd_rs_addr  input  REG_ADDR_W  source register being read.
- fwd_hit  output  1  a pending entry targets fwd_rs_addr.
- fwd_data  output  DATA_WIDTH  youngest pending value for fwd_rs_addr.
- occupancy  output  log2(DEPTH)+1  valid entries.

## Operation
- **Storage:** circular FIFO with write pointer, read pointer and count. Both pointers wrap modulo DEPTH.
- **Accept:** accept = res_valid && res_ready. res_ready = (count < DEPTH).
  - No pass-through when full. An entry popped in the same cycle does not raise res_ready.
- **x0 results:** a result with res_rd == 0 is accepted (handshake completes) and then discarded. It is not pushed, and count is unchanged.
- **Present:** rf_wr_en = (count != 0). rf_wr_addr and rf_wr_data come straight from the head entry's registers, with no combinational path from res_*.
- **Pop:** pop = rf_wr_en && rf_wr_gnt. The read pointer advances and count decrements.
  - While rf_wr_gnt is low, the head and all outputs hold stable.
- **Simultaneous accept and pop:** count is unchanged, and both pointers advance.
- **Empty:** rf_wr_en = 0. rf_wr_addr and rf_wr_data are don't-care; the bench checks only that they are not X.
- **Ordering:** strictly in order. Two entries may share the same rd; both are written in order.
- **Forwarding:** combinational search over valid entries.
  - fwd_hit = 1 when any valid entry has rd == fwd_rs_addr and fwd_rs_addr != 0.
  - fwd_data = value of the youngest matching entry, i.e. the one closest to the write pointer.
  - A result being accepted in the same cycle is not searched.
- **Reset:** asserting reset at any time, including mid-drain, clears pointers, count and entry valid state.
  - During reset: rf_wr_en = 0, rf_wr_addr = 0, rf_wr_data = 0, fwd_hit = 0, fwd_data = 0, occupancy = 0.
  - res_ready = 1 from the first edge after reset deasserts.

## Timing
- Accept at edge N gives rf_wr_en = 1 in cycle N+1 if the FIFO was empty. Minimum latency is 1 cycle.
- With rf_wr_gnt held high and a result every cycle, throughput is 1 result per cycle at steady occupancy 1.
- Forwarding reflects the register state of the current cycle. An entry popped at edge N is no longer forwarded in cycle N+1.
- res_ready depends only on count (registered). It is not a function of rf_wr_gnt.

## Configuration
- Macro: WB_FORWARD_EN.
- Defined: forwarding search as described above.
- Undefined: no comparators are built, fwd_hit = 0 and fwd_data = 0 permanently. The fwd_rs_addr, fwd_hit and fwd_data ports remain on the interface, so instantiation is identical in both builds.

## Structure
- Shared header Execution_param.vh gains:
  - WB_DEPTH default.
  - REG_ADDR_W.
  - Zero-register index constant `REG_X0`.
- DATA_WIDTH stays in system_param.vh.
- One sub-module, wb_fifo: storage, pointers, count, full/empty.
- Top level adds the x0 filter, the register-file interface and the forward search.

## Test plan
- **Single result:** reset, then result rd=5, data=0x0000_00FF with rf_wr_gnt=1. Next cycle rf_wr_en=1, addr=5, data=0xFF. The cycle after that, rf_wr_en=0 and occupancy=0.
- **Fill and back-pressure:** rf_wr_gnt=0, 4 results (rd 1..4). res_ready=0 and occupancy=4; a 5th offer is not accepted. Raise rf_wr_gnt: writes go out in order rd 1,2,3,4 on consecutive cycles, and res_ready returns to 1 after the first pop.
- **x0 discard:** result rd=0, data=0xDEAD_BEEF is accepted (res_ready=1), occupancy stays 0 and no write occurs.
- **Forwarding (WB_FORWARD_EN defined):** rf_wr_gnt=0, push rd=7/0x11, then rd=7/0x22. fwd_rs_addr=7 gives hit=1, data=0x22. fwd_rs_addr=0 gives hit=0. Built without the macro, hit=0 throughout.
- **Simultaneous accept and pop:** occupancy 2, rf_wr_gnt=1 and res_valid=1 for 3 cycles. Occupancy stays 2 and write order matches push order.
- **Reset mid-drain:** occupancy 3, assert reset asynchronously mid-cycle. All outputs go to 0 immediately. After release, no stale entries are written.
